button_debounce_multi: RTL
==========================

// Module: button_debounce_multi
// PURPOSE
//   Parametrised N-channel push-button front end for the clock's set/adjust keys.
//   Per channel: 2-FF synchroniser, counter debounce, edge pulses, and a hold FSM
//   that issues a long-press pulse and then auto-repeat pulses while held.
//   Sits between the board key pins and the time-setting control logic.
// PARAMETERS
//   N_BTN           4           number of independent button channels
//   DEBOUNCE_CYCLES 500_000     consecutive mismatch cycles before accepting a level (10 ms @ 50 MHz)
//   LONG_CYCLES     50_000_000  cycles from press to long-press pulse (1 s)
//   REPEAT_CYCLES   10_000_000  period of auto-repeat pulses after long press (200 ms)
//   ACTIVE_LOW      1           1: pressed = input 0; 0: pressed = input 1
// PORTS
//   clk             in   1      system clock, 50 MHz
//   rst             in   1      asynchronous reset, active-low
//   button_in       in   N_BTN  raw asynchronous key inputs
//   button_out      out  N_BTN  debounced level (same polarity as button_in)
//   button_posedge  out  N_BTN  1-cycle pulse on button_out rising
//   button_negedge  out  N_BTN  1-cycle pulse on button_out falling
//   button_held     out  N_BTN  level: debounced pressed state
//   button_long     out  N_BTN  1-cycle pulse at long-press threshold
//   button_repeat   out  N_BTN  1-cycle pulse every REPEAT_CYCLES after long press
// BEHAVIOUR
//   - Reset (rst=0, async): sync FFs and button_out = idle level ({N{ACTIVE_LOW}});
//     all pulses, button_held = 0; counters 0; FSM IDLE.
//   - Debounce: cnt++ each cycle sync != button_out; any cycle sync == button_out clears cnt.
//     At cnt == DEBOUNCE_CYCLES-1 with mismatch: button_out <= sync, cnt <= 0.
//     Latency: button_out changes on the (DEBOUNCE_CYCLES+2)th rising edge counting the
//     first edge that samples the settled input. Glitches < DEBOUNCE_CYCLES: no effect.
//   - posedge/negedge registered, asserted in the same cycle button_out changes.
//   - Press event = negedge if ACTIVE_LOW else posedge; release = the opposite edge.
//   - Hold FSM per channel (states IDLE, PRESSED, LONG):
//     IDLE->PRESSED on press (hold_cnt<=0, button_held<=1 same cycle as edge pulse).
//     PRESSED: hold_cnt++; press at cycle P -> button_long pulse at P+LONG_CYCLES, ->LONG.
//     LONG: rpt_cnt wraps at REPEAT_CYCLES; button_repeat at P+LONG_CYCLES+k*REPEAT_CYCLES, k>=1.
//     Any state -> IDLE on release; button_held<=0 in release-edge cycle.
//   - Release coinciding with long or repeat threshold cycle: release wins, no pulse.
//   - Channels fully independent; simultaneous events on several channels all reported.
//   - Counter widths $clog2(param+1); no overflow (hold_cnt stops in LONG).
//   - Reset mid-operation: everything returns to reset values; if input is still pressed
//     after rst deasserts, a fresh press edge follows after debounce latency.
//   - Elaboration error if DEBOUNCE_CYCLES<2, REPEAT_CYCLES<1, LONG_CYCLES<=DEBOUNCE_CYCLES.
// STRUCTURE
//   - btn_defs.vh: hold-FSM state encodings (IDLE=2'd0, PRESSED=2'd1, LONG=2'd2).
//   - Sub-module button_debounce_ch: one channel (sync, debounce, edges, hold FSM);
//     top instantiates N_BTN copies in a generate loop, shares only clk/rst.
// TESTING (N_BTN=2, DEBOUNCE_CYCLES=8, LONG_CYCLES=64, REPEAT_CYCLES=16, ACTIVE_LOW=1, 20 ns clk)
//   1 Reset: rst=0, inputs 1 -> button_out=2'b11, all pulses/held 0; release rst -> no pulses.
//   2 Bounce: ch0 toggles every 3 cycles x10 then settles 0 -> exactly one negedge[0],
//     button_out[0] falls on 10th edge after settle; ch1 untouched.
//   3 Glitch: ch0 low for 7 cycles -> no change, no pulses; 8+ cycles -> one negedge.
//   4 Long press: ch1 held low, press at P -> long at P+64, repeat at P+80,P+96,P+112;
//     release -> posedge[1], held[1]=0 in that cycle, no further repeats.
//   5 Simultaneous/boundary: both channels pressed same cycle -> identical pulses;
//     release landing at P+64 -> no long pulse.
//   6 Reset in LONG: rst=0 -> outputs to reset values at once; rst=1 with input low ->
//     new negedge and held after 10 edges, long again 64 cycles later.

Source files
------------

// File: rtl/button_debounce_multi_pkg.sv
// Shared types for the multi-channel key front end.
// Hold-FSM state encodings and counter sizing helper.
package button_debounce_multi_pkg;

  typedef enum logic [1:0] {
    HOLD_IDLE    = 2'd0,
    HOLD_PRESSED = 2'd1,
    HOLD_LONG    = 2'd2
  } hold_st_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/button_debounce_multi_ch.sv
// One key channel: 2-FF sync, counter debounce, edge pulses,
// and a hold FSM giving long-press and auto-repeat pulses.
module button_debounce_multi_ch
  import button_debounce_multi_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic out_o,
  output logic pos_o,
  output logic neg_o,
  output logic held_o,
  output logic long_o,
  output logic rpt_o
);

  localparam int unsigned DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int unsigned HW = cnt_w(LONG_CYCLES);
  localparam int unsigned RW = cnt_w(REPEAT_CYCLES);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);
  localparam logic [HW-1:0] LG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] LG_ONE  = HW'(1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] RP_ONE  = RW'(1);

  logic [1:0]    sync_q;
  logic          out_q, out_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          pos_q, pos_d;
  logic          neg_q, neg_d;
  hold_st_e      st_q, st_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic          held_q, held_d;
  logic          long_q, long_d;
  logic          rep_q, rep_d;
  logic          press, rel;

  always_comb begin
    out_d = out_q;
    cnt_d = '0;
    if (sync_q[1] != out_q) begin
      if (cnt_q == DB_LAST) out_d = sync_q[1];
      else                  cnt_d = cnt_q + DB_ONE;
    end
    pos_d = out_d & ~out_q;
    neg_d = ~out_d & out_q;
    press = ACTIVE_LOW ? neg_d : pos_d;
    rel   = ACTIVE_LOW ? pos_d : neg_d;
  end

  // Release takes priority over any threshold hit in the same cycle
  always_comb begin
    st_d   = st_q;
    hold_d = hold_q;
    rpt_d  = rpt_q;
    long_d = 1'b0;
    rep_d  = 1'b0;
    if (rel) begin
      st_d = HOLD_IDLE;
    end else begin
      unique case (st_q)
        HOLD_IDLE: begin
          if (press) begin
            st_d   = HOLD_PRESSED;
            hold_d = '0;
          end
        end
        HOLD_PRESSED: begin
          if (hold_q == LG_LAST) begin
            st_d   = HOLD_LONG;
            long_d = 1'b1;
            rpt_d  = '0;
          end else begin
            hold_d = hold_q + LG_ONE;
          end
        end
        HOLD_LONG: begin
          if (rpt_q == RP_LAST) begin
            rpt_d = '0;
            rep_d = 1'b1;
          end else begin
            rpt_d = rpt_q + RP_ONE;
          end
        end
        default: st_d = HOLD_IDLE;
      endcase
    end
    held_d = (st_d != HOLD_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{ACTIVE_LOW}};
      out_q  <= ACTIVE_LOW;
      cnt_q  <= '0;
      pos_q  <= 1'b0;
      neg_q  <= 1'b0;
      st_q   <= HOLD_IDLE;
      hold_q <= '0;
      rpt_q  <= '0;
      held_q <= 1'b0;
      long_q <= 1'b0;
      rep_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      neg_q  <= neg_d;
      st_q   <= st_d;
      hold_q <= hold_d;
      rpt_q  <= rpt_d;
      held_q <= held_d;
      long_q <= long_d;
      rep_q  <= rep_d;
    end
  end

  assign out_o  = out_q;
  assign pos_o  = pos_q;
  assign neg_o  = neg_q;
  assign held_o = held_q;
  assign long_o = long_q;
  assign rpt_o  = rep_q;

endmodule

// File: rtl/button_debounce_multi.sv
// N-channel push-button front end for the set/adjust keys.
// Channels are independent and share only clock and reset.
module button_debounce_multi
  import button_debounce_multi_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] button_in,
  output logic [N_BTN-1:0] button_out,
  output logic [N_BTN-1:0] button_posedge,
  output logic [N_BTN-1:0] button_negedge,
  output logic [N_BTN-1:0] button_held,
  output logic [N_BTN-1:0] button_long,
  output logic [N_BTN-1:0] button_repeat
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1 ||
      LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_cfg
    $error("button_debounce_multi: illegal cycle parameters");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_debounce_multi_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst),
      .btn_i (button_in[i]),
      .out_o (button_out[i]),
      .pos_o (button_posedge[i]),
      .neg_o (button_negedge[i]),
      .held_o(button_held[i]),
      .long_o(button_long[i]),
      .rpt_o (button_repeat[i])
    );
  end

endmodule
